// File: rtl/tanh3slices_inv_pkg.sv
// Shared Q5.11 constants and segment decode for the 3-slice tanh PWL curve,
// common to the forward tanh block and its inverse.
package tanh3slices_inv_pkg;

  localparam int DATA_W = 16;
  localparam int COEF_W = 16;
  localparam int DIFF_W = 17;
  localparam int PROD_W = 34;
  localparam int FRAC_W = 11;
  localparam int STAGES = 3;

  // Knees of the curve in the tanh domain: tanh_pwl(+-1) and tanh_pwl(+-3).
  localparam logic signed [DATA_W-1:0] Y_KNEE   = 16'sd1560;
  localparam logic signed [DATA_W-1:0] Y_KNEE_N = -16'sd1560;
  localparam logic signed [DATA_W-1:0] Y_SAT    = 16'sd2038;
  localparam logic signed [DATA_W-1:0] Y_SAT_N  = -16'sd2038;

  localparam logic signed [DIFF_W-1:0] Y_OFS    = 17'sd1321;
  localparam logic signed [DIFF_W-1:0] Y_OFS_N  = -17'sd1321;

  // Reciprocal slopes: 1/0.76159 and 1/0.11673.
  localparam logic signed [COEF_W-1:0] K_INNER  = 16'sd2689;
  localparam logic signed [COEF_W-1:0] K_OUTER  = 16'sd17545;

  localparam logic signed [DATA_W-1:0] X_MAX    = 16'sd6144;
  localparam logic signed [DATA_W-1:0] X_MIN    = -16'sd6144;

  typedef enum logic [2:0] {
    SEG_INNER,
    SEG_UPPER,
    SEG_LOWER,
    SEG_SAT_HI,
    SEG_SAT_LO
  } seg_e;

  function automatic seg_e decode_seg(input logic signed [DATA_W-1:0] y);
    if (y > Y_SAT)    return SEG_SAT_HI;
    if (y < Y_SAT_N)  return SEG_SAT_LO;
    if (y >= Y_KNEE)  return SEG_UPPER;
    if (y <= Y_KNEE_N) return SEG_LOWER;
    return SEG_INNER;
  endfunction

endpackage

// File: rtl/tanh3slices_inv_lane.sv
// One lane of the inverse 3-slice tanh: decode, subtract/multiply, then
// shift/clamp/mux. All stages advance together on en.
module tanh3_inv_lane
  import tanh3slices_inv_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic signed [DATA_W-1:0] y,
  output logic signed [DATA_W-1:0] x,
  output logic                     oor
);

  function automatic logic signed [DATA_W-1:0] clamp_x(
    input logic signed [PROD_W-1:0] v
  );
    if (v > PROD_W'(X_MAX)) return X_MAX;
    if (v < PROD_W'(X_MIN)) return X_MIN;
    return v[DATA_W-1:0];
  endfunction

  seg_e                     seg_s1;
  logic signed [DIFF_W-1:0] off_s1;
  logic signed [COEF_W-1:0] coef_s1;

  always_comb begin
    seg_s1  = decode_seg(y);
    off_s1  = '0;
    coef_s1 = K_INNER;
    case (seg_s1)
      SEG_UPPER: begin off_s1 = Y_OFS;   coef_s1 = K_OUTER; end
      SEG_LOWER: begin off_s1 = Y_OFS_N; coef_s1 = K_OUTER; end
      default: ;
    endcase
  end

  // ---- S1 -> S2 boundary
  seg_e                     seg_p0;
  logic signed [DATA_W-1:0] y_p0;
  logic signed [DIFF_W-1:0] off_p0;
  logic signed [COEF_W-1:0] coef_p0;

  always_ff @(posedge clk) begin
    if (en) begin
      seg_p0  <= seg_s1;
      y_p0    <= y;
      off_p0  <= off_s1;
      coef_p0 <= coef_s1;
    end
  end

  logic signed [DIFF_W-1:0] diff_s2;
  logic signed [PROD_W-1:0] prod_s2;

  always_comb begin
    diff_s2 = $signed({y_p0[DATA_W-1], y_p0}) - off_p0;
    prod_s2 = PROD_W'(diff_s2) * PROD_W'(coef_p0);
  end

  // ---- S2 -> S3 boundary
  seg_e                     seg_p1;
  logic signed [PROD_W-1:0] prod_p1;

  always_ff @(posedge clk) begin
    if (en) begin
      seg_p1  <= seg_p0;
      prod_p1 <= prod_s2;
    end
  end

  logic signed [DATA_W-1:0] x_s3;
  logic                     oor_s3;

  always_comb begin
    x_s3   = clamp_x(prod_p1 >>> FRAC_W);
    oor_s3 = 1'b0;
    case (seg_p1)
      SEG_SAT_HI: begin x_s3 = X_MAX; oor_s3 = 1'b1; end
      SEG_SAT_LO: begin x_s3 = X_MIN; oor_s3 = 1'b1; end
      default: ;
    endcase
  end

  // ---- S3 output registers
  logic signed [DATA_W-1:0] x_p2;
  logic                     oor_p2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_p2   <= '0;
      oor_p2 <= 1'b0;
    end else if (en) begin
      x_p2   <= x_s3;
      oor_p2 <= oor_s3;
    end
  end

  assign x   = x_p2;
  assign oor = oor_p2;

endmodule

// File: rtl/tanh3slices_inv.sv
// Two-lane inverse of the 3-slice tanh PWL with a valid/ready pipeline that
// stalls as a whole, plus a saturating out-of-range event counter.
module tanh3slices_inv
  import tanh3slices_inv_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic signed [DATA_W-1:0] y0_in,
  input  logic signed [DATA_W-1:0] y1_in,
  input  logic                     valid_in,
  output logic                     ready_out,
  output logic signed [DATA_W-1:0] x0_out,
  output logic signed [DATA_W-1:0] x1_out,
  output logic                     oor0_out,
  output logic                     oor1_out,
  output logic                     valid_out,
  input  logic                     ready_in,
  input  logic                     clr_cnt,
  output logic [CNT_W-1:0]         oor_count
);

  function automatic logic [CNT_W-1:0] sat_add(
    input logic [CNT_W-1:0] c,
    input logic [1:0]       inc
  );
    logic [CNT_W:0] s;
    s = {1'b0, c} + {{(CNT_W-1){1'b0}}, inc};
    return s[CNT_W] ? '1 : s[CNT_W-1:0];
  endfunction

  logic stall;
  logic en;
  logic hs_out;
  logic vld_p0, vld_p1, vld_p2;

  assign stall     = vld_p2 & ~ready_in;
  assign en        = ~stall;
  assign ready_out = ~stall;
  assign hs_out    = vld_p2 & ready_in;
  assign valid_out = vld_p2;

  // With en high, ready_out is high too, so valid_in alone marks a handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else if (en) begin
      vld_p0 <= valid_in;
      vld_p1 <= vld_p0;
      vld_p2 <= vld_p1;
    end
  end

  tanh3_inv_lane u_lane0 (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .y     (y0_in),
    .x     (x0_out),
    .oor   (oor0_out)
  );

  tanh3_inv_lane u_lane1 (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .y     (y1_in),
    .x     (x1_out),
    .oor   (oor1_out)
  );

  logic [1:0] oor_inc;
  assign oor_inc = {1'b0, oor0_out} + {1'b0, oor1_out};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      oor_count <= '0;
    end else if (clr_cnt) begin
      oor_count <= '0;
    end else if (hs_out) begin
      oor_count <= sat_add(oor_count, oor_inc);
    end
  end

endmodule

// File: tb/tb_tanh3slices_inv.sv
// Directed bench for tanh3slices_inv: hand-computed vectors, stall, counter
// saturation/clear and mid-flight reset.
module tb_tanh3slices_inv;

  localparam int CNT_W = 4;

  logic               clk;
  logic               rst_n;
  logic signed [15:0] y0_in, y1_in;
  logic               valid_in;
  logic               ready_out;
  logic signed [15:0] x0_out, x1_out;
  logic               oor0_out, oor1_out;
  logic               valid_out;
  logic               ready_in;
  logic               clr_cnt;
  logic [CNT_W-1:0]   oor_count;

  tanh3slices_inv #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .y0_in     (y0_in),
    .y1_in     (y1_in),
    .valid_in  (valid_in),
    .ready_out (ready_out),
    .x0_out    (x0_out),
    .x1_out    (x1_out),
    .oor0_out  (oor0_out),
    .oor1_out  (oor1_out),
    .valid_out (valid_out),
    .ready_in  (ready_in),
    .clr_cnt   (clr_cnt),
    .oor_count (oor_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int y0; int y1; int x0; int x1; int o0; int o1;
  } vec_t;

  vec_t vt [10];
  vec_t exp_q [$];
  int   n_vec;
  int   n_err;

  task automatic chk(input string tag, input int obs, input int req);
    n_vec++;
    if (obs !== req) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, req);
    end
  endtask

  // Drive point: just after the falling edge.
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic send(input int idx, input bit track);
    valid_in = 1'b1;
    y0_in    = vt[idx].y0[15:0];
    y1_in    = vt[idx].y1[15:0];
    for (int g = 0; g < 40; g++) begin
      #1;
      if (ready_out) begin
        if (track) exp_q.push_back(vt[idx]);
        tick();
        return;
      end
      tick();
    end
    chk("send_timeout", 0, 1);
  endtask

  task automatic drain();
    for (int g = 0; g < 60 && exp_q.size() != 0; g++) tick();
    if (exp_q.size() != 0) chk("drain", exp_q.size(), 0);
    tick();
    tick();
  endtask

  // Output scoreboard: looks after inputs for the coming edge have settled.
  always @(negedge clk) begin : mon_blk
    vec_t e;
    #2;
    if (rst_n && valid_out && ready_in) begin
      if (exp_q.size() == 0) begin
        chk("extra_beat", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("x0", x0_out, e.x0);
        chk("x1", x1_out, e.x1);
        chk("oor0", oor0_out, e.o0);
        chk("oor1", oor1_out, e.o1);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int seen;
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0; valid_in = 1'b0; y0_in = '0; y1_in = '0;
    ready_in = 1'b1; clr_cnt = 1'b0;

    vt[0] = '{1024,      0,  1344,     0, 0, 0};
    vt[1] = '{1560,  -1560,  2047, -2048, 0, 0};
    vt[2] = '{2038,  -2038,  6142, -6143, 0, 0};
    vt[3] = '{2039, -32768,  6144, -6144, 1, 1};
    vt[4] = '{1559,  -1559,  2046, -2047, 0, 0};
    vt[5] = '{32767, -2039,  6144, -6144, 1, 1};
    vt[6] = '{-1024,  1700, -1345,  3246, 0, 0};
    vt[7] = '{1,        -1,     1,    -2, 0, 0};
    vt[8] = '{-1800,     0, -4104,     0, 0, 0};
    vt[9] = '{2500,    100,  6144,   131, 1, 0};

    repeat (2) tick();
    chk("rst_valid_out", valid_out, 0);
    chk("rst_ready_out", ready_out, 1);
    chk("rst_x0", x0_out, 0);
    chk("rst_x1", x1_out, 0);
    chk("rst_oor0", oor0_out, 0);
    chk("rst_oor1", oor1_out, 0);
    chk("rst_count", oor_count, 0);

    rst_n = 1'b1;
    tick();

    // Latency: single beat, valid_out appears on the third edge.
    send(0, 1'b1);
    valid_in = 1'b0;
    tick();
    chk("lat2_valid", valid_out, 0);
    tick();
    chk("lat3_valid", valid_out, 1);

    for (int i = 1; i < 10; i++) send(i, 1'b1);
    valid_in = 1'b0;
    drain();
    chk("cnt_mix", oor_count, 5);

    // Stall: fill the pipe with ready_in low, hold 5 cycles, then release.
    ready_in = 1'b0;
    send(6, 1'b1);
    send(7, 1'b1);
    send(8, 1'b1);
    valid_in = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk("stall_valid", valid_out, 1);
      chk("stall_ready", ready_out, 0);
      chk("stall_x0", x0_out, -1345);
      chk("stall_x1", x1_out, 3246);
      tick();
    end
    ready_in = 1'b1;
    drain();

    // Counter saturation at 15 for CNT_W = 4.
    for (int i = 0; i < 5; i++) send(3, 1'b1);
    valid_in = 1'b0;
    drain();
    chk("cnt_15", oor_count, 15);
    send(5, 1'b1);
    valid_in = 1'b0;
    drain();
    chk("cnt_hold", oor_count, 15);

    // Clear coinciding with an out-of-range output handshake.
    send(9, 1'b1);
    valid_in = 1'b0;
    for (int g = 0; g < 20 && !valid_out; g++) tick();
    chk("clr_wait", valid_out, 1);
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    chk("cnt_clr", oor_count, 0);
    drain();

    // Reset with two beats in flight: neither may appear afterwards.
    send(1, 1'b0);
    send(2, 1'b0);
    valid_in = 1'b0;
    ready_in = 1'b0;
    tick();
    chk("pre_rst_valid", valid_out, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", valid_out, 0);
    chk("rst_mid_x0", x0_out, 0);
    chk("rst_mid_ready", ready_out, 1);
    tick();
    tick();
    rst_n = 1'b1;
    ready_in = 1'b1;
    seen = 0;
    for (int g = 0; g < 8; g++) begin
      tick();
      if (valid_out) seen++;
    end
    chk("ghost_beats", seen, 0);

    send(0, 1'b1);
    valid_in = 1'b0;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/tanh3slices_inv.md
TANH3SLICES_INV -- requirements
Module: tanh3slices_inv

Interface
REQ-001 SHALL have parameter CNT_W, default 16, the width of the out-of-range event counter.
REQ-002 SHALL have port clk  input  1  rising-edge clock; the single clock for all state.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports y0_in, y1_in  input  16 signed each  lane 0/1 tanh-domain operands, Q5.11 (1.0 = 2048).
REQ-005 SHALL have port valid_in  input  1  input beat valid.
REQ-006 SHALL have port ready_out  output  1  block accepts an input beat this cycle.
REQ-007 SHALL have ports x0_out, x1_out  output  16 signed each  lane 0/1 inverse result, Q5.11.
REQ-008 SHALL have ports oor0_out, oor1_out  output  1 each  lane input was outside the invertible range.
REQ-009 SHALL have port valid_out  output  1  output beat valid.
REQ-010 SHALL have port ready_in  input  1  downstream accepts the output beat.
REQ-011 SHALL have port clr_cnt  input  1  synchronous clear of oor_count.
REQ-012 SHALL have port oor_count  output  CNT_W  saturating count of out-of-range lane events.

Function
REQ-013 SHALL compute, per lane and independently, the exact inverse of the team's 3-slice tanh PWL curve (slopes 0.11673 / 0.76159, intercepts ±0.64486, breakpoints x = ±1, ±3).
REQ-014 SHALL decode as follows: |y| < 1560 -> inner segment; 1560 <= y <= 2038 -> upper segment; -2038 <= y <= -1560 -> lower segment; y > 2038 -> saturate high; y < -2038 -> saturate low.
REQ-015 SHALL compute the inner segment as x = (y * 2689) >>> 11, where 2689 is 1/0.76159 in Q5.11.
REQ-016 SHALL compute the upper segment as x = ((y - 1321) * 17545) >>> 11 and the lower segment as x = ((y + 1321) * 17545) >>> 11, where 17545 is 1/0.11673 in Q5.11.
REQ-017 SHALL form the difference at 17-bit signed width and keep the product at full width (at least 34 bits) before the arithmetic shift, which floors.
REQ-018 SHALL clamp the shifted result to [-6144, 6144] and then truncate it to 16 bits.
REQ-019 SHALL drive x = +6144 (+3.0) with oor = 1 on saturate high and x = -6144 with oor = 1 on saturate low; oor = 0 otherwise.
REQ-020 SHALL be a 3-stage pipeline: S1 decode and select constants, S2 subtract and multiply, S3 shift, clamp, mux and register outputs.
REQ-021 SHALL have a latency of 3 cycles from the input handshake to valid_out with no stall.
REQ-022 SHALL sustain a throughput of one beat per cycle while ready_in = 1.
REQ-023 SHALL transfer an input when valid_in & ready_out are both 1, and an output when valid_out & ready_in are both 1.
REQ-024 SHALL define stall = valid_out & ~ready_in; stall freezes S1, S2 and S3 together.
REQ-025 SHALL drive ready_out = ~stall combinationally; bubbles do not stall.
REQ-026 SHALL hold x*_out, oor*_out and valid_out stable while stalled, with no beat lost or duplicated.
REQ-027 SHALL advance pipeline-stage valid bits on non-stall cycles only, loading 0 when no input handshake occurs.
REQ-028 SHALL increment oor_count at each output handshake by oor0_out + oor1_out (0, 1 or 2), saturating at all-ones.
REQ-029 SHALL give clr_cnt priority, forcing oor_count to 0 on that edge even when an increment coincides.

Reset
REQ-030 SHALL, while rst_n = 0, asynchronously clear all stage valid bits, valid_out, x0_out, x1_out, oor0_out, oor1_out and oor_count to 0; ready_out then reads 1.
REQ-031 SHALL discard in-flight beats when reset asserts mid-operation, with no output until a new input handshake after release.

Structure
REQ-032 SHALL place the Q5.11 constants (1560, 2038, 1321, 2689, 17545, ±6144) in a shared package used jointly with the forward tanh block.
REQ-033 SHALL implement one sub-module, tanh3_inv_lane, holding the per-lane decode/multiply/clamp datapath, instantiated twice; the top holds handshake, stall and counter.

Verification
REQ-034 SHALL cover: y0 = 1024, y1 = 0, ready_in = 1 -> 3 cycles later x0 = 1344, x1 = 0, oor = 0/0.
REQ-035 SHALL cover: y0 = 1560, y1 = -1560 -> x0 = 2047, x1 = -2048; y0 = 2038 -> x0 = 6142.
REQ-036 SHALL cover: y0 = 2039, y1 = -32768 -> x0 = 6144, x1 = -6144, oor = 1/1, oor_count += 2.
REQ-037 SHALL cover: back-to-back beats with ready_in held low 5 cycles -> outputs stable, ready_out = 0, all beats delivered in order after release.
REQ-038 SHALL cover: oor_count preset near saturation with CNT_W = 4 -> holds at 15; clr_cnt coincident with an oor handshake -> reads 0.
REQ-039 SHALL cover: rst_n asserted with 2 beats in flight -> valid_out = 0 immediately; neither beat appears after release.
